// File: rtl/jelly_wishbone_slave_ram_if.sv
// ---------------------------------------------------------------------------
// jelly_wishbone_slave_ram_if
//   Wishbone classic slave bus bundle for jelly_wishbone_slave_ram.
//   Signal names keep the slave-side _i/_o suffixes of the RAM block.
//
//   s_wb_adr_i  word address            (master -> slave)
//   s_wb_dat_i  write data              (master -> slave)
//   s_wb_we_i   write enable            (master -> slave)
//   s_wb_sel_i  byte lane select        (master -> slave)
//   s_wb_stb_i  strobe                  (master -> slave)
//   s_wb_dat_o  read data               (slave -> master)
//   s_wb_ack_o  acknowledge             (slave -> master)
// ---------------------------------------------------------------------------
interface jelly_wishbone_slave_ram_if #(
  parameter int ADR_WIDTH = 12,
  parameter int DAT_WIDTH = 32,
  parameter int SEL_WIDTH = 4
);
  logic [ADR_WIDTH-1:0] s_wb_adr_i;
  logic [DAT_WIDTH-1:0] s_wb_dat_i;
  logic [DAT_WIDTH-1:0] s_wb_dat_o;
  logic                 s_wb_we_i;
  logic [SEL_WIDTH-1:0] s_wb_sel_i;
  logic                 s_wb_stb_i;
  logic                 s_wb_ack_o;

  modport master (
    output s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
    input  s_wb_dat_o, s_wb_ack_o
  );

  modport slave (
    input  s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
    output s_wb_dat_o, s_wb_ack_o
  );
endinterface

// File: rtl/jelly_wishbone_slave_ram.sv
// ---------------------------------------------------------------------------
// jelly_wishbone_slave_ram
//   Wishbone slave backed by a byte-lane RAM with a programmable number of
//   wait states before the single-cycle acknowledge.
//
//   Ports
//     clk       single clock, rising edge
//     reset_n   asynchronous, active-low reset (RAM contents survive it)
//     s_wb      jelly_wishbone_slave_ram_if.slave bus bundle
//     rd_count  completed reads  (16 bit, wraps)
//     wr_count  completed writes (16 bit, wraps)
//
//   Build option
//     JELLY_WISHBONE_SLAVE_RAM_STATS_EN  defined: rd_count/wr_count count
//                                        completed transfers; undefined:
//                                        both outputs tied to zero.
//
//   Transfer flow: IDLE -(stb)-> WAIT (WAIT_CYCLES edges) -> ACK (1 cycle)
//   -> IDLE. The request is captured on the edge entering ACK; a write
//   commits on the edge leaving ACK.
// ---------------------------------------------------------------------------

// One byte lane of the RAM: synchronous write, combinational read.
// Contents start at zero and are never touched by reset.
module jelly_wishbone_slave_ram_lane #(
  parameter int MEM_ADR_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [MEM_ADR_WIDTH-1:0] wadr,
  input  logic [7:0]               wdat,
  input  logic [MEM_ADR_WIDTH-1:0] radr,
  output logic [7:0]               rdat
);
  localparam int DEPTH = 1 << MEM_ADR_WIDTH;

  logic [7:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[wadr] <= wdat;
  end

  assign rdat = mem[radr];
endmodule

module jelly_wishbone_slave_ram #(
  parameter int ADR_WIDTH     = 12,
  parameter int DAT_SIZE      = 2,
  parameter int DAT_WIDTH     = (8 << DAT_SIZE),
  parameter int SEL_WIDTH     = (1 << DAT_SIZE),
  parameter int MEM_ADR_WIDTH = 8,
  parameter int WAIT_CYCLES   = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  jelly_wishbone_slave_ram_if.slave    s_wb,
  output logic [15:0]                  rd_count,
  output logic [15:0]                  wr_count
);
  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Request as captured on entry to ACK. Only the RAM index part of the
  // address is kept; upper address bits alias onto the same words.
  typedef struct packed {
    logic                     we;
    logic [SEL_WIDTH-1:0]     sel;
    logic [MEM_ADR_WIDTH-1:0] adr;
    logic [DAT_WIDTH-1:0]     dat;
  } req_t;

  state_t               state, state_nxt;
  logic [7:0]           cnt, cnt_nxt;
  logic                 take;
  req_t                 req_in, req_q;
  logic                 ack_q;
  logic [DAT_WIDTH-1:0] dat_o_q;
  logic [DAT_WIDTH-1:0] rd_word;
  logic                 commit;

  logic [SEL_WIDTH-1:0][7:0] rd_lane;
  logic [SEL_WIDTH-1:0][7:0] wr_lane;

  // Upper address bits are deliberately ignored.
  logic unused_adr;
  assign unused_adr = ^s_wb.s_wb_adr_i;

  assign req_in.we  = s_wb.s_wb_we_i;
  assign req_in.sel = s_wb.s_wb_sel_i;
  assign req_in.adr = s_wb.s_wb_adr_i[MEM_ADR_WIDTH-1:0];
  assign req_in.dat = s_wb.s_wb_dat_i;

  // ---------------------------------------------------------------------
  // Next-state logic. 'take' marks the edge that enters ACK: the request
  // is latched and the RAM word is loaded into dat_o on that same edge.
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_wb.s_wb_stb_i) begin
          if (WAIT_INIT == 8'd0) begin
            state_nxt = ACK;
            take      = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        // A dropped strobe aborts: nothing is written, acked or counted.
        if (!s_wb.s_wb_stb_i) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else if (cnt == 8'd1) begin
          state_nxt = ACK;
          cnt_nxt   = 8'd0;
          take      = 1'b1;
        end else begin
          cnt_nxt   = cnt - 8'd1;
        end
      end
      ACK: begin
        // Always return to IDLE so a held strobe is sampled afresh there.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      ack_q   <= 1'b0;
      dat_o_q <= '0;
      req_q   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack_q <= (state_nxt == ACK);
      if (take) begin
        req_q   <= req_in;
        dat_o_q <= rd_word;
      end else begin
        dat_o_q <= '0;
      end
    end
  end

  assign s_wb.s_wb_ack_o = ack_q;
  assign s_wb.s_wb_dat_o = dat_o_q;

  // Write commits on the edge leaving ACK. Because reset forces the state
  // to IDLE asynchronously, a reset anywhere in the transfer suppresses it.
  assign commit  = (state == ACK);
  assign wr_lane = req_q.dat;
  assign rd_word = rd_lane;

  for (genvar k = 0; k < SEL_WIDTH; k++) begin : g_lane
    jelly_wishbone_slave_ram_lane #(
      .MEM_ADR_WIDTH (MEM_ADR_WIDTH)
    ) u_lane (
      .clk  (clk),
      .we   (commit && req_q.we && req_q.sel[k]),
      .wadr (req_q.adr),
      .wdat (wr_lane[k]),
      .radr (req_in.adr),
      .rdat (rd_lane[k])
    );
  end

  // ---------------------------------------------------------------------
  // Transfer statistics
  // ---------------------------------------------------------------------
`ifdef JELLY_WISHBONE_SLAVE_RAM_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (commit) begin
      if (req_q.we) wr_count <= wr_count + 16'd1;
      else          rd_count <= rd_count + 16'd1;
    end
  end
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_jelly_wishbone_slave_ram.sv
module tb_jelly_wishbone_slave_ram;
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

`ifdef JELLY_WISHBONE_SLAVE_RAM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  jelly_wishbone_slave_ram_if #(.ADR_WIDTH(12), .DAT_WIDTH(32), .SEL_WIDTH(4)) wb1 ();
  jelly_wishbone_slave_ram_if #(.ADR_WIDTH(12), .DAT_WIDTH(32), .SEL_WIDTH(4)) wb3 ();
  jelly_wishbone_slave_ram_if #(.ADR_WIDTH(12), .DAT_WIDTH(32), .SEL_WIDTH(4)) wb0 ();

  logic [15:0] rd1, wr1, rd3, wr3, rd0, wr0;

  jelly_wishbone_slave_ram #(.WAIT_CYCLES(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .s_wb(wb1), .rd_count(rd1), .wr_count(wr1));
  jelly_wishbone_slave_ram #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .s_wb(wb3), .rd_count(rd3), .wr_count(wr3));
  jelly_wishbone_slave_ram #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .s_wb(wb0), .rd_count(rd0), .wr_count(wr0));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Reference RAM for u_dut (256 words, address aliasing on low 8 bits)
  logic [31:0] model [256];
  logic [31:0] exp_q [$];
  int          exp_rd = 0;
  int          exp_wr = 0;

  // Scoreboard consumer: read data is popped and compared on each read ack;
  // outside ack dat_o must be zero.
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset_n) begin
      if (wb1.s_wb_ack_o) begin
        if (!wb1.s_wb_we_i) begin
          if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("rd_data", wb1.s_wb_dat_o, e);
          end
        end
      end else begin
        chk("dat_o_idle", wb1.s_wb_dat_o, 32'd0);
      end
    end
  end

  // One transfer on u_dut with stb held until ack; expectations pushed at issue.
  task automatic wb_xfer(input logic we, input logic [11:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
    int cyc;
    logic [7:0] idx;
    idx = adr[7:0];
    if (we) begin
      for (int k = 0; k < 4; k++) if (sel[k]) model[idx][8*k +: 8] = dat[8*k +: 8];
      exp_wr++;
    end else begin
      exp_q.push_back(model[idx]);
      exp_rd++;
    end
    @(posedge clk); #1;
    wb1.s_wb_adr_i = adr;
    wb1.s_wb_dat_i = dat;
    wb1.s_wb_sel_i = sel;
    wb1.s_wb_we_i  = we;
    wb1.s_wb_stb_i = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!wb1.s_wb_ack_o && cyc < 20);
    chk("ack_lat", cyc, 2);
    wb1.s_wb_stb_i = 1'b0;
    @(posedge clk); #1;
    chk("ack_1cyc", {31'd0, wb1.s_wb_ack_o}, 32'd0);
  endtask

  // One transfer on u_dut3; returns cycles to ack and the data seen with ack.
  task automatic w3_xfer(input logic we, input logic [11:0] adr, input logic [31:0] dat,
                         output int cyc, output logic [31:0] rdat);
    @(posedge clk); #1;
    wb3.s_wb_adr_i = adr;
    wb3.s_wb_dat_i = dat;
    wb3.s_wb_sel_i = 4'hF;
    wb3.s_wb_we_i  = we;
    wb3.s_wb_stb_i = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!wb3.s_wb_ack_o && cyc < 20);
    rdat = wb3.s_wb_dat_o;
    wb3.s_wb_stb_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int          cyc;
    logic [31:0] rdat;
    logic        ack_seen;
    logic [3:0]  pat;

    for (int i = 0; i < 256; i++) model[i] = 32'd0;
    wb1.s_wb_adr_i = '0; wb1.s_wb_dat_i = '0; wb1.s_wb_sel_i = '0;
    wb1.s_wb_we_i  = 1'b0; wb1.s_wb_stb_i = 1'b0;
    wb3.s_wb_adr_i = '0; wb3.s_wb_dat_i = '0; wb3.s_wb_sel_i = '0;
    wb3.s_wb_we_i  = 1'b0; wb3.s_wb_stb_i = 1'b0;
    wb0.s_wb_adr_i = '0; wb0.s_wb_dat_i = '0; wb0.s_wb_sel_i = '0;
    wb0.s_wb_we_i  = 1'b0; wb0.s_wb_stb_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",  {31'd0, wb1.s_wb_ack_o}, 32'd0);
    chk("rst_dat",  wb1.s_wb_dat_o, 32'd0);
    chk("rst_rdc",  {16'd0, rd1}, 32'd0);
    chk("rst_wrc",  {16'd0, wr1}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Full write / read back, byte-lane merge, aliasing
    wb_xfer(1'b1, 12'h005, 32'h12345678, 4'b1111);
    wb_xfer(1'b0, 12'h005, 32'h0,        4'b1111);
    wb_xfer(1'b1, 12'h005, 32'hAABBCCDD, 4'b0101);
    wb_xfer(1'b0, 12'h005, 32'h0,        4'b0000);
    wb_xfer(1'b1, 12'h105, 32'hCAFEF00D, 4'b1111);
    wb_xfer(1'b0, 12'h005, 32'h0,        4'b0001);
    wb_xfer(1'b0, 12'hF05, 32'h0,        4'b1111);
    wb_xfer(1'b1, 12'h010, 32'h0BADC0DE, 4'b1111);

    // Random traffic
    repeat (12) begin
      wb_xfer(1'($urandom_range(0, 1)), 12'($urandom), $urandom, 4'($urandom));
    end
    wb_xfer(1'b0, 12'h010, 32'h0, 4'b1111);

    chk("rd_count", {16'd0, rd1}, STATS ? 32'(16'(exp_rd)) : 32'd0);
    chk("wr_count", {16'd0, wr1}, STATS ? 32'(16'(exp_wr)) : 32'd0);

    // WAIT_CYCLES=3: strobe dropped after two cycles aborts the write
    @(posedge clk); #1;
    wb3.s_wb_adr_i = 12'h020; wb3.s_wb_dat_i = 32'hDEADBEEF;
    wb3.s_wb_sel_i = 4'hF;    wb3.s_wb_we_i  = 1'b1; wb3.s_wb_stb_i = 1'b1;
    ack_seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; ack_seen |= wb3.s_wb_ack_o; end
    wb3.s_wb_stb_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; ack_seen |= wb3.s_wb_ack_o; end
    chk("abort_ack", {31'd0, ack_seen}, 32'd0);
    chk("abort_rdc", {16'd0, rd3}, 32'd0);
    chk("abort_wrc", {16'd0, wr3}, 32'd0);
    w3_xfer(1'b0, 12'h020, 32'h0, cyc, rdat);
    chk("w3_lat",    cyc,  32'd4);
    chk("abort_ram", rdat, 32'd0);

    // WAIT_CYCLES=3: inputs changed early in WAIT; values at ACK entry win
    @(posedge clk); #1;
    wb3.s_wb_adr_i = 12'h031; wb3.s_wb_dat_i = 32'h11111111;
    wb3.s_wb_sel_i = 4'hF;    wb3.s_wb_we_i  = 1'b1; wb3.s_wb_stb_i = 1'b1;
    @(posedge clk); #1;
    wb3.s_wb_adr_i = 12'h030; wb3.s_wb_dat_i = 32'h22222222;
    cyc = 1;
    do begin @(posedge clk); #1; cyc++; end while (!wb3.s_wb_ack_o && cyc < 20);
    chk("w3_wr_lat", cyc, 32'd4);
    wb3.s_wb_stb_i = 1'b0;
    @(posedge clk); #1;
    w3_xfer(1'b0, 12'h030, 32'h0, cyc, rdat);
    chk("late_adr_new", rdat, 32'h22222222);
    w3_xfer(1'b0, 12'h031, 32'h0, cyc, rdat);
    chk("late_adr_old", rdat, 32'd0);

    // WAIT_CYCLES=0 with strobe held: ack 0,1,0,1 then low
    @(posedge clk); #1;
    wb0.s_wb_adr_i = 12'h000; wb0.s_wb_we_i = 1'b0;
    wb0.s_wb_sel_i = 4'hF;    wb0.s_wb_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pat[3-i] = wb0.s_wb_ack_o;
      @(posedge clk); #1;
    end
    wb0.s_wb_stb_i = 1'b0;
    chk("w0_pattern", {28'd0, pat}, 32'h5);
    chk("w0_after",   {31'd0, wb0.s_wb_ack_o}, 32'd0);

    // Asynchronous reset while a write to 0x010 sits in WAIT
    @(posedge clk); #1;
    wb1.s_wb_adr_i = 12'h010; wb1.s_wb_dat_i = 32'h5555AAAA;
    wb1.s_wb_sel_i = 4'hF;    wb1.s_wb_we_i  = 1'b1; wb1.s_wb_stb_i = 1'b1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ack", {31'd0, wb1.s_wb_ack_o}, 32'd0);
    chk("arst_dat", wb1.s_wb_dat_o, 32'd0);
    chk("arst_rdc", {16'd0, rd1}, 32'd0);
    chk("arst_wrc", {16'd0, wr1}, 32'd0);
    wb1.s_wb_stb_i = 1'b0;
    wb1.s_wb_we_i  = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("arst_noack", {31'd0, wb1.s_wb_ack_o}, 32'd0);
    end
    wb_xfer(1'b0, 12'h010, 32'h0, 4'hF);

    // Counter check after reset: 3 writes + 2 reads in total
    wb_xfer(1'b1, 12'h040, 32'h01020304, 4'hF);
    wb_xfer(1'b1, 12'h041, 32'hA5A5A5A5, 4'b1000);
    wb_xfer(1'b0, 12'h041, 32'h0, 4'hF);
    wb_xfer(1'b1, 12'h140, 32'hFFFFFFFF, 4'b0010);
    chk("cnt_wr3", {16'd0, wr1}, STATS ? 32'd3 : 32'd0);
    chk("cnt_rd2", {16'd0, rd1}, STATS ? 32'd2 : 32'd0);

    @(posedge clk); #1;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/jelly_wishbone_slave_ram.md
JELLY_WISHBONE_SLAVE_RAM -- requirements
Module: jelly_wishbone_slave_ram

Interface
REQ-001 Parameters SHALL be: ADR_WIDTH, default 12, Wishbone word-address width.
REQ-002 DAT_SIZE, default 2, data width exponent (0:8bit, 1:16bit, 2:32bit).
REQ-003 DAT_WIDTH, default (8 << DAT_SIZE), data width.
REQ-004 SEL_WIDTH, default (1 << DAT_SIZE), byte-select width.
REQ-005 MEM_ADR_WIDTH, default 8, log2 of RAM depth in words (MEM_ADR_WIDTH <= ADR_WIDTH).
REQ-006 WAIT_CYCLES, default 1, wait states inserted before ack (0..255).
REQ-007 Ports SHALL be: clk  in  1  single clock, all logic on rising edge.
REQ-008 reset_n  in  1  reset, asynchronous, active-low.
REQ-009 s_wb_adr_i  in  ADR_WIDTH  word address.
REQ-010 s_wb_dat_i  in  DAT_WIDTH  write data.
REQ-011 s_wb_dat_o  out  DAT_WIDTH  read data.
REQ-012 s_wb_we_i  in  1  write enable.
REQ-013 s_wb_sel_i  in  SEL_WIDTH  byte lane select.
REQ-014 s_wb_stb_i  in  1  strobe.
REQ-015 s_wb_ack_o  out  1  acknowledge.
REQ-016 rd_count  out  16  completed reads; wr_count  out  16  completed writes.

Function
REQ-017 States SHALL be IDLE, WAIT, ACK; s_wb_ack_o SHALL be registered and high only in ACK.
REQ-018 IDLE: stb_i=1 sampled -> WAIT with wait counter loaded to WAIT_CYCLES; WAIT_CYCLES=0 -> directly ACK.
REQ-019 WAIT: counter decrements each edge; counter=1 at an edge -> ACK; stb_i=0 at any edge -> IDLE (abort, no write, no ack, no count).
REQ-020 ACK SHALL last exactly one cycle, then IDLE unconditionally; a strobe held or reissued is sampled fresh in IDLE (no back-to-back ack).
REQ-021 Latency: stb_i first high in cycle C -> ack high in cycle C+1+WAIT_CYCLES, provided stb_i held.
REQ-022 RAM index SHALL be s_wb_adr_i[MEM_ADR_WIDTH-1:0]; upper bits ignored (aliasing wrap).
REQ-023 Write: at the edge ending ACK with we_i=1, each byte lane k with sel_i[k]=1 SHALL take dat_i lane k; other lanes unchanged.
REQ-024 Read: s_wb_dat_o SHALL be loaded with RAM word on entry to ACK, held during ACK, forced 0 in all other cycles; sel_i does not mask read data.
REQ-025 Address, we, sel, dat_i SHALL be sampled at the edge entering ACK; changes earlier in WAIT have no effect.
REQ-026 rd_count/wr_count SHALL increment by 1 at the edge ending a read/write ACK, wrap 0xFFFF -> 0x0000.

Reset
REQ-027 reset_n=0 SHALL immediately force state IDLE, s_wb_ack_o=0, s_wb_dat_o=0, wait counter=0, rd_count=0, wr_count=0.
REQ-028 Reset mid-transaction SHALL abandon it without a RAM write; RAM contents SHALL NOT be cleared by reset.
REQ-029 RAM SHALL initialise to all zero at time 0.

Configuration
REQ-030 Macro JELLY_WISHBONE_SLAVE_RAM_STATS_EN defined: rd_count/wr_count implemented per REQ-026.
REQ-031 Macro undefined: counters not built, rd_count and wr_count tied to 0; all other behaviour identical.

Verification
REQ-032 WAIT_CYCLES=1, write adr 0x005 dat 0x12345678 sel 1111, stb held -> ack one cycle at C+2; readback of 0x005 returns 0x12345678 with ack.
REQ-033 Write 0xAABBCCDD sel 0101 over 0x12345678 at 0x005 -> read returns 0x12BB56DD.
REQ-034 MEM_ADR_WIDTH=8, write 0xCAFEF00D to adr 0x105 -> read at 0x005 returns 0xCAFEF00D.
REQ-035 WAIT_CYCLES=3, stb dropped after 2 cycles -> no ack, RAM unchanged, counters unchanged.
REQ-036 reset_n pulsed low during WAIT of a write -> ack/dat_o/counters 0 asynchronously, target word unchanged, next access completes normally.
REQ-037 STATS_EN defined, 3 writes + 2 reads -> wr_count=3, rd_count=2; undefined -> both 0; WAIT_CYCLES=0 stb held 4 cycles -> ack pattern 0,1,0,1.
